// File: rtl/force_sweep_pkg.sv
// force_sweep_pkg: shared types and helpers for the force-sweep control blocks
//   state_t  - sweep FSM encoding
//   elem_lo  - low bit of element i in a packed N*W bus
package force_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FORCING   = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_t;

    function automatic int elem_lo(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/en_edge_det.sv
// en_edge_det: registers a level request and decodes its rising/falling edges
//   clk, rst_n - clock, async active-low reset
//   en         - request level
//   rise, fall - single-cycle edge strobes (combinational from en and its register)
module en_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise,
    output logic fall
);

    logic en_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= en;

    assign rise = en & ~en_q;
    assign fall = ~en & en_q;

endmodule

// File: rtl/force_sweep_ctrl.sv
// force_sweep_ctrl: sequences force/release of an N-element array port, one element per clock
//   clk, rst_n - clock, async active-low reset
//   en         - force request level; rise starts a force sweep, fall a release sweep
//   i_a        - force value, captured when a force sweep starts
//   d_in       - normal per-element drive, element i at [i*W +: W]
//   o_a        - resolved per-element value
//   force_mask - bit i set while element i is forced
//   busy       - sweep in progress
//   done       - one-cycle pulse at the end of each sweep
module force_sweep_ctrl
    import force_sweep_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [W-1:0]   i_a,
    input  logic [N*W-1:0] d_in,
    output logic [N*W-1:0] o_a,
    output logic [N-1:0]   force_mask,
    output logic           busy,
    output logic           done
);

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [W-1:0]  fv, fv_d;
    logic [N-1:0]  mask_d;
    logic          pend, pend_d, done_d, rise, fall, last;

    en_edge_det u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            fv         <= '0;
            pend       <= 1'b0;
            force_mask <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            fv         <= fv_d;
            pend       <= pend_d;
            force_mask <= mask_d;
            done       <= done_d;
        end

    assign last = idx == IW'(N - 1);

    // A rise during a release (or a glitch into HELD) is remembered and replayed
    // from IDLE, so a release always finishes before the next force begins.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        fv_d    = fv;
        mask_d  = force_mask;
        done_d  = 1'b0;
        pend_d  = fall ? 1'b0 : (rise && (state == HELD || state == RELEASING)) ? 1'b1 : pend;
        case (state)
            IDLE:
                if (rise || (pend && en)) begin
                    fv_d    = i_a;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = FORCING;
                end
            FORCING:
                if (fall) begin
                    idx_d   = '0;
                    state_d = RELEASING;
                end else begin
                    mask_d[idx] = 1'b1;
                    done_d      = last;
                    state_d     = last ? HELD : FORCING;
                    idx_d       = last ? idx : idx + 1'b1;
                end
            HELD:
                if (fall) begin
                    idx_d   = '0;
                    state_d = RELEASING;
                end
            RELEASING: begin
                mask_d[idx] = 1'b0;
                done_d      = last;
                state_d     = last ? IDLE : RELEASING;
                idx_d       = last ? idx : idx + 1'b1;
            end
        endcase
    end

    always_comb busy = (state == FORCING) || (state == RELEASING);

    for (genvar i = 0; i < N; i++) begin : g_mux
        assign o_a[elem_lo(i, W) +: W] = force_mask[i] ? fv : d_in[elem_lo(i, W) +: W];
    end

endmodule

// File: tb/tb_force_sweep_ctrl.sv
// tb_force_sweep_ctrl: directed scoreboard bench for force_sweep_ctrl (N=8, W=1)
module tb_force_sweep_ctrl;

    localparam int N = 8;
    localparam int W = 1;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic [W-1:0]   i_a   = '0;
    logic [N*W-1:0] d_in  = 8'hA5;
    logic [N*W-1:0] o_a;
    logic [N-1:0]   force_mask;
    logic           busy, done;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] mask;
        logic [7:0] oa;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_n;
    int    errors = 0;
    int    checks = 0;
    int    dones  = 0;

    always #5 clk = ~clk;

    force_sweep_ctrl #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .i_a       (i_a),
        .d_in      (d_in),
        .o_a       (o_a),
        .force_mask(force_mask),
        .busy      (busy),
        .done      (done)
    );

    // Monitor: one expected snapshot per checked cycle, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) dones++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if ({busy, done, force_mask, o_a} !== mon_e) begin
                errors++;
                $display("FAIL %s: got busy=%b done=%b mask=%h o_a=%h, want busy=%b done=%b mask=%h o_a=%h",
                         mon_n, busy, done, force_mask, o_a, mon_e.busy, mon_e.done, mon_e.mask, mon_e.oa);
            end
        end
    end

    task automatic chk_now(input string nm, input exp_t e);
        checks++;
        if ({busy, done, force_mask, o_a} !== e) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b mask=%h o_a=%h, want busy=%b done=%b mask=%h o_a=%h",
                     nm, busy, done, force_mask, o_a, e.busy, e.done, e.mask, e.oa);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge;
    // f is the force value the DUT should be holding at that point.
    task automatic step(input logic e, input logic ia, input logic [7:0] din,
                        input logic b, input logic d, input logic [7:0] m,
                        input logic f, input string nm);
        @(negedge clk);
        en   = e;
        i_a  = ia;
        d_in = din;
        exp_q.push_back('{b, d, m, (m & {8{f}}) | (~m & din)});
        name_q.push_back(nm);
    endtask

    initial begin
        #3 chk_now("reset", '{1'b0, 1'b0, 8'h00, 8'hA5});
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 8'hA5, 0, 0, 8'h00, 0, "idle");

        step(1, 0, 8'hFF, 1, 0, 8'h00, 0, "force_start");
        for (int i = 0; i < 8; i++)
            step(1, 0, 8'hFF, i < 7, i == 7, 8'((2 << i) - 1), 0, "force_sweep");
        step(1, 1, 8'hFF, 0, 0, 8'hFF, 0, "held_ia_ignored");

        step(0, 1, 8'hFF, 1, 0, 8'hFF, 0, "release_start");
        for (int i = 0; i < 8; i++)
            step(0, 1, 8'hFF, i < 7, i == 7, 8'(8'hFF << (i + 1)), 0, "release_sweep");
        step(0, 1, 8'hFF, 0, 0, 8'h00, 0, "release_idle");

        step(1, 1, 8'h00, 1, 0, 8'h00, 1, "abort_start");
        for (int i = 0; i < 3; i++)
            step(1, 1, 8'h00, 1, 0, 8'((2 << i) - 1), 1, "abort_force");
        step(0, 1, 8'h00, 1, 0, 8'h07, 1, "abort_fall");
        for (int i = 0; i < 8; i++)
            step(0, 1, 8'h00, i < 7, i == 7, 8'(8'h07 & (8'hFF << (i + 1))), 1, "abort_release");
        step(0, 1, 8'h00, 0, 0, 8'h00, 1, "abort_idle");

        step(1, 0, 8'hAA, 1, 0, 8'h00, 0, "rs_force_start");
        for (int i = 0; i < 8; i++)
            step(1, 0, 8'hAA, i < 7, i == 7, 8'((2 << i) - 1), 0, "rs_force");
        step(0, 0, 8'hAA, 1, 0, 8'hFF, 0, "rs_release_start");
        for (int i = 0; i < 8; i++)
            step(1, 0, 8'hAA, i < 7, i == 7, 8'(8'hFF << (i + 1)), 0, "rs_release_pend");
        step(1, 1, 8'hAA, 1, 0, 8'h00, 1, "rs_restart");
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'hAA, 1, 0, 8'((2 << i) - 1), 1, "rs_force_new_fv");

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1 chk_now("async_reset", '{1'b0, 1'b0, 8'h00, 8'hAA});
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 8'h3C, 0, 0, 8'h00, 0, "post_reset_idle");
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        checks++;
        if (dones != 5) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, want 5", dones);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/force_sweep_ctrl.md
Name: force_sweep_ctrl

Overview:
- Sequencer that produces the force/release control for an N-element array port.
- On a rising edge of `en`, it captures a force value and forces the elements one per clock.
- On a falling edge of `en`, it releases them one per clock.
- It drives the resolved per-element value, the per-element force mask, and busy/done status to the consumer downstream.

Parameters:
- N, 8, number of array elements (>=2).
- W, 1, width of one element in bits.
- IW, $clog2(N), width of the element index.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- en, in, 1: force request level. Rising edge starts a force sweep; falling edge starts a release sweep.
- i_a, in, W: force value source, sampled only on the en rising edge.
- d_in, in, N*W: normal (unforced) drive value per element; element i is bits [i*W +: W].
- o_a, out, N*W: resolved value per element.
- force_mask, out, N: bit i high means element i is currently forced.
- busy, out, 1: high while a force or release sweep is in progress.
- done, out, 1: single-cycle pulse when a sweep completes.

Behaviour:
- Reset values (async, when rst_n=0):
  - en_q=0, state=IDLE, idx=0, fv=0, pend=0.
  - force_mask=0, done=0, busy=0.
  - o_a follows d_in combinationally.
- Edge detection:
  - en_q is en registered.
  - rise = en & ~en_q; fall = ~en & en_q.
  - Both are evaluated at every clock edge.
- FSM states: IDLE, FORCING, HELD, RELEASING.
- IDLE:
  - On rise: fv<=i_a, idx<=0, go to FORCING.
  - If pend=1 and en=1: same action, with fv<=i_a sampled that cycle; pend<=0.
- FORCING:
  - Each clock: force_mask[idx]<=1, idx<=idx+1.
  - When idx==N-1: set the last bit, done<=1, go to HELD.
- HELD:
  - Mask stays all-ones.
  - On fall: idx<=0, go to RELEASING.
- RELEASING:
  - Each clock: force_mask[idx]<=0, idx<=idx+1.
  - When idx==N-1: clear the last bit, done<=1, go to IDLE.
- Abort: fall while in FORCING → idx<=0, go to RELEASING. Clearing bits that were never set has no effect.
- Restart:
  - rise in RELEASING or HELD (HELD is reachable only via glitch) sets pend.
  - fall while pend=1 clears pend.
  - Release always completes before a new force begins.
- Latency (en rises before edge k, so en_q=0 and en=1 at edge k):
  - state=FORCING after edge k.
  - force_mask[0]=1 after edge k+1.
  - force_mask[N-1]=1 and done=1 after edge k+N.
  - done=0 after edge k+N+1.
  - The release sweep has symmetric latency from the fall edge.
- Output mapping:
  - o_a[i] = force_mask[i] ? fv : d_in[i], purely combinational from registers and d_in.
  - busy = (state==FORCING) | (state==RELEASING), decoded combinationally from state.
- Index:
  - idx saturates; it never wraps past N-1.
  - idx is reset to 0 on every sweep start.
- fv is held constant from capture until the next capture. Changes on i_a during FORCING or HELD have no effect.
- done is registered. It is never high for two consecutive cycles; back-to-back sweeps have at least one IDLE or HELD cycle between them.
- Reset mid-sweep: all state returns to reset values immediately; the mask clears asynchronously.

Decomposition:
- Package force_sweep_pkg:
  - state enum (IDLE=2'd0, FORCING=2'd1, HELD=2'd2, RELEASING=2'd3).
  - Helper function for the element slice of the N*W bus.
- Sub-module en_edge_det: one register plus rise/fall decode. It is reused by other force-control blocks.
- The mux array is a generate loop inside the top module; no sub-module.

Test Plan:
- Reset, then en=0, d_in=8'hA5 (W=1) → o_a=8'hA5, force_mask=0, busy=0, done=0.
- i_a=0, d_in=8'hFF, en 0→1 held → force_mask goes 01,03,07,…,FF over 8 cycles; o_a ends at 8'h00; done pulses exactly once on the cycle the mask reaches FF.
- From HELD, en 1→0 → mask clears from bit 0 upward over 8 cycles; o_a returns to d_in; done pulses once; busy is high exactly 8 cycles.
- en rises, then falls after 3 cycles (mask=07) → RELEASING from idx 0; mask reaches 0 within 8 cycles; exactly one done pulse (release), none from the aborted force.
- en toggles 1→0→1 while RELEASING → pend set; on reaching IDLE with en=1, a new force sweep starts with fv = the i_a at that cycle.
- rst_n=0 asserted asynchronously mid-FORCING (mask=0F) → mask=0, busy=0, o_a=d_in before the next clock edge.
